// File: rtl/pipel_pkg.sv
// Shared types and helpers for the flow-controlled pipelined arithmetic stream.
package pipel_pkg;

    // Operand-stage function select, sampled together with the operands.
    typedef enum logic [1:0] {
        MODE_ADD   = 2'b00,
        MODE_SUB   = 2'b01,
        MODE_SUM2  = 2'b10,
        MODE_PASSC = 2'b11
    } mode_t;

    // Width of the occupancy counter: must hold 0 .. DEPTH+2.
    function automatic int OCC_W(input int depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/pipel_stage.sv
// One enable-gated pipeline register carrying a valid bit, a data word and a tag.
module pipel_stage #(
    parameter int DATA_W = 40,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic [TAG_W-1:0]  tag_r;

    // Shift the upstream contents in when the pipeline advances, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            tag_r   <= '0;
        end else if (en) begin
            valid_r <= in_valid;
            data_r  <= in_data;
            tag_r   <= in_tag;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_tag   = tag_r;

endmodule

// File: rtl/pipel_stream.sv
// Flow-controlled pipelined arithmetic block: op stage, DEPTH delay stages and a
// registered full-width multiply, all advancing together under a global stall.
module pipel_stream
    import pipel_pkg::*;
#(
    parameter int N     = 20,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               mode,
    input  logic [N-1:0]             a,
    input  logic [N-1:0]             b,
    input  logic [N-1:0]             c,
    input  logic [N-1:0]             d,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*N-1:0]           f,
    output logic [TAG_W-1:0]         out_tag,
    output logic [OCC_W(DEPTH)-1:0]  occupancy
);

    localparam int OW = OCC_W(DEPTH);
    // Interior stages carry {s, d} packed into one word.
    localparam int DW = 2 * N;

    logic              adv_s;
    logic              accept_s;
    logic              xfer_s;
    logic [N-1:0]      sum_s;
    logic [N-1:0]      diff_s;
    logic [N-1:0]      s_next_s;
    logic [2*N-1:0]    ext_s_s;
    logic [2*N-1:0]    ext_d_s;
    logic [2*N-1:0]    prod_s;

    logic              op_valid_r;
    logic [DW-1:0]     op_data_r;
    logic [TAG_W-1:0]  op_tag_r;

    logic              out_valid_r;
    logic [2*N-1:0]    f_r;
    logic [TAG_W-1:0]  out_tag_r;
    logic [OW-1:0]     occ_r;

    // Index 0 is the op stage; index DEPTH feeds the multiply stage.
    logic [DEPTH:0]    chain_valid_s;
    logic [DW-1:0]     chain_data_s [0:DEPTH];
    logic [TAG_W-1:0]  chain_tag_s  [0:DEPTH];

    // Single global stall: nothing moves while the output holds an unconsumed result.
    assign adv_s    = !out_valid_r || out_ready;
    assign accept_s = in_valid && adv_s;
    assign xfer_s   = out_valid_r && out_ready;
    assign in_ready = adv_s;

    // Mode-selected op-stage function, all arithmetic modulo 2^N.
    always_comb begin
        sum_s    = a + b;
        diff_s   = a - b;
        s_next_s = '0;
        case (mode_t'(mode))
            MODE_ADD:   s_next_s = sum_s;
            MODE_SUB:   s_next_s = diff_s;
            MODE_SUM2:  s_next_s = sum_s + diff_s;
            MODE_PASSC: s_next_s = c;
            default:    s_next_s = '0;
        endcase
    end

    // Op stage: capture s, d and the tag of an accepted operand set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid_r <= 1'b0;
            op_data_r  <= '0;
            op_tag_r   <= '0;
        end else if (adv_s) begin
            op_valid_r <= accept_s;
            op_data_r  <= {s_next_s, d};
            op_tag_r   <= in_tag;
        end
    end

    assign chain_valid_s[0] = op_valid_r;
    assign chain_data_s[0]  = op_data_r;
    assign chain_tag_s[0]   = op_tag_r;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_delay
            pipel_stage #(
                .DATA_W (DW),
                .TAG_W  (TAG_W)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .en        (adv_s),
                .in_valid  (chain_valid_s[g]),
                .in_data   (chain_data_s[g]),
                .in_tag    (chain_tag_s[g]),
                .out_valid (chain_valid_s[g+1]),
                .out_data  (chain_data_s[g+1]),
                .out_tag   (chain_tag_s[g+1])
            );
        end
    endgenerate

    // Zero-extend both factors so the product keeps all 2N bits.
    assign ext_s_s = {{N{1'b0}}, chain_data_s[DEPTH][DW-1:N]};
    assign ext_d_s = {{N{1'b0}}, chain_data_s[DEPTH][N-1:0]};
    assign prod_s  = ext_s_s * ext_d_s;

    // Multiply stage: register the full product and the tag of the last delay stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            f_r         <= '0;
            out_tag_r   <= '0;
        end else if (adv_s) begin
            out_valid_r <= chain_valid_s[DEPTH];
            f_r         <= prod_s;
            out_tag_r   <= chain_tag_s[DEPTH];
        end
    end

    // Occupancy tracks items inside the pipe: +1 per accept, -1 per output transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_r <= '0;
        end else begin
            occ_r <= occ_r + {{(OW-1){1'b0}}, accept_s} - {{(OW-1){1'b0}}, xfer_s};
        end
    end

    assign out_valid = out_valid_r;
    assign f         = f_r;
    assign out_tag   = out_tag_r;
    assign occupancy = occ_r;

endmodule

// File: tb/tb_pipel_stream.sv
// Self-checking bench for pipel_stream: directed mode vectors, a stalled burst,
// randomized traffic against a queue-based reference model, and async reset.
module tb_pipel_stream;

    localparam int N     = 20;
    localparam int DEPTH = 2;
    localparam int TAG_W = 4;
    localparam int OW    = 3;
    localparam int LAT   = DEPTH + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        mode;
    logic [N-1:0]      a, b, c, d;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [2*N-1:0]    f;
    logic [TAG_W-1:0]  out_tag;
    logic [OW-1:0]     occupancy;

    pipel_stream #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .out_tag   (out_tag),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*N-1:0]   f;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } item_t;

    item_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    // Values observed in the most recent tick, just before its rising edge.
    logic             obs_acc, obs_xfer, obs_valid, obs_ready, obs_oready;
    logic [2*N-1:0]   obs_f;
    logic [TAG_W-1:0] obs_tag;
    logic [OW-1:0]    obs_occ;
    int               obs_qsize;
    int               obs_cyc;

    // Reference: s computed with plain integer arithmetic modulo 2^N, then s*d.
    function automatic logic [2*N-1:0] ref_f(input logic [1:0] md, input logic [N-1:0] aa,
                                             input logic [N-1:0] bb, input logic [N-1:0] cc,
                                             input logic [N-1:0] dd);
        longint m = longint'(1) << N;
        longint x = longint'(aa);
        longint y = longint'(bb);
        longint s;
        case (md)
            2'd0:    s = (x + y) % m;
            2'd1:    s = (x - y + m) % m;
            2'd2:    s = ((x + y) + (x - y + m)) % m;
            default: s = longint'(cc);
        endcase
        return (2*N)'(s * longint'(dd));
    endfunction

    task automatic rand_ops();
        mode = 2'($urandom_range(0, 3));
        a = ($urandom_range(0, 7) == 0) ? {N{1'b1}} : N'($urandom);
        b = ($urandom_range(0, 7) == 0) ? {N{1'b1}} : N'($urandom);
        c = N'($urandom);
        d = ($urandom_range(0, 7) == 0) ? {N{1'b1}} : N'($urandom);
    endtask

    // One clock: sample just after the inputs settle, log accepts, advance to the next negedge.
    task automatic tick();
        #1;
        obs_valid  = out_valid;
        obs_ready  = in_ready;
        obs_oready = out_ready;
        obs_f      = f;
        obs_tag    = out_tag;
        obs_occ    = occupancy;
        obs_acc    = in_valid && in_ready;
        obs_xfer   = out_valid && out_ready;
        obs_qsize  = exp_q.size();
        obs_cyc    = cyc;
        if (obs_acc) exp_q.push_back('{ref_f(mode, a, b, c, d), in_tag, cyc});
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 2'd0;
        a = '0; b = '0; c = '0; d = '0; in_tag = '0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (f !== '0) begin bad++; $display("FAIL reset_f got=%0h want=0", f); end
        total++; if (out_tag !== '0) begin bad++; $display("FAIL reset_out_tag got=%0h want=0", out_tag); end
        total++; if (occupancy !== '0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        rst = 1'b0;
        tick();
        total++; if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle in_ready=%0b out_valid=%0b want 1/0", obs_ready, obs_valid);
        end
    endtask

    task automatic test_modes();
        logic [1:0]     tm [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [N-1:0]   ta [4] = '{20'd3, 20'd2, 20'd10, 20'd0};
        logic [N-1:0]   tb [4] = '{20'd5, 20'd5, 20'd4, 20'd0};
        logic [N-1:0]   tc [4] = '{20'd0, 20'd0, 20'd0, 20'hFFFFF};
        logic [N-1:0]   td [4] = '{20'd7, 20'd1, 20'd3, 20'hFFFFF};
        logic [2*N-1:0] tf [4] = '{40'd56, 40'd1048573, 40'd60, 40'hFFFFE00001};
        item_t it;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mode = tm[i]; a = ta[i]; b = tb[i]; c = tc[i]; d = td[i];
            in_tag = 4'(i + 1); in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            total++; if (obs_acc !== 1'b1) begin bad++; $display("FAIL mode%0d_accept got=%0b want=1", i, obs_acc); end
            for (int k = 0; k < 12; k++) begin
                tick();
                if (obs_xfer) break;
            end
            if (!obs_xfer || obs_qsize == 0) begin
                total++; bad++; $display("FAIL mode%0d_timeout got=no_output want=output", i);
            end else begin
                it = exp_q.pop_front();
                total++; if (obs_f !== tf[i]) begin bad++; $display("FAIL mode%0d_f got=%0h want=%0h", i, obs_f, tf[i]); end
                total++; if (obs_tag !== 4'(i + 1)) begin bad++; $display("FAIL mode%0d_tag got=%0d want=%0d", i, obs_tag, i + 1); end
                total++; if (obs_cyc - it.cyc != LAT) begin bad++; $display("FAIL mode%0d_latency got=%0d want=%0d", i, obs_cyc - it.cyc, LAT); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, peak = 0, stall_cnt = 0;
        logic prev_stall = 1'b0;
        logic [2*N-1:0] prev_f = '0;
        logic [TAG_W-1:0] prev_tag = '0;
        item_t it;
        for (int cc = 0; cc < 40 && got < 6; cc++) begin
            in_valid = (sent < 6);
            rand_ops();
            in_tag = 4'(sent);
            out_ready = !(cc >= 5 && cc < 8);
            tick();
            if (obs_acc) sent++;
            if (!obs_ready) stall_cnt++;
            if (int'(obs_occ) > peak) peak = int'(obs_occ);
            total++; if (obs_ready !== !(obs_valid && !obs_oready)) begin
                bad++; $display("FAIL b2b_in_ready c=%0d got=%0b want=%0b", cc, obs_ready, !(obs_valid && !obs_oready));
            end
            total++; if (int'(obs_occ) != obs_qsize) begin
                bad++; $display("FAIL b2b_occupancy c=%0d got=%0d want=%0d", cc, obs_occ, obs_qsize);
            end
            if (prev_stall) begin
                total++; if (obs_valid !== 1'b1 || obs_f !== prev_f || obs_tag !== prev_tag) begin
                    bad++; $display("FAIL b2b_hold c=%0d got=%0h/%0d want=%0h/%0d", cc, obs_f, obs_tag, prev_f, prev_tag);
                end
            end
            prev_stall = obs_valid && !obs_oready;
            prev_f = obs_f; prev_tag = obs_tag;
            if (obs_xfer) begin
                if (obs_qsize == 0) begin
                    total++; bad++; $display("FAIL b2b_extra_output got=tag%0d want=none", obs_tag);
                end else begin
                    it = exp_q.pop_front();
                    total++; if (obs_tag !== 4'(got)) begin bad++; $display("FAIL b2b_order got=%0d want=%0d", obs_tag, got); end
                    total++; if (obs_f !== it.f) begin bad++; $display("FAIL b2b_f got=%0h want=%0h", obs_f, it.f); end
                    got++;
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (got != 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", got); end
        total++; if (peak != 4) begin bad++; $display("FAIL b2b_peak_occ got=%0d want=4", peak); end
        total++; if (stall_cnt != 3) begin bad++; $display("FAIL b2b_stall_cycles got=%0d want=3", stall_cnt); end
    endtask

    task automatic test_random();
        logic prev_stall = 1'b0;
        logic [2*N-1:0] prev_f = '0;
        item_t it;
        for (int cc = 0; cc < 340; cc++) begin
            in_valid  = (cc < 300) && ($urandom_range(0, 3) != 0);
            out_ready = (cc >= 300) || ($urandom_range(0, 2) != 0);
            rand_ops();
            in_tag = 4'($urandom);
            tick();
            total++; if (obs_ready !== !(obs_valid && !obs_oready) || int'(obs_occ) != obs_qsize) begin
                bad++; $display("FAIL rnd_flow c=%0d in_ready=%0b occ=%0d want occ=%0d", cc, obs_ready, obs_occ, obs_qsize);
            end
            if (prev_stall) begin
                total++; if (obs_valid !== 1'b1 || obs_f !== prev_f) begin
                    bad++; $display("FAIL rnd_hold c=%0d got=%0h want=%0h", cc, obs_f, prev_f);
                end
            end
            prev_stall = obs_valid && !obs_oready;
            prev_f = obs_f;
            if (obs_xfer) begin
                if (obs_qsize == 0) begin
                    total++; bad++; $display("FAIL rnd_extra_output got=%0h want=none", obs_f);
                end else begin
                    it = exp_q.pop_front();
                    total++; if (obs_f !== it.f || obs_tag !== it.tag) begin
                        bad++; $display("FAIL rnd_item got=%0h/%0d want=%0h/%0d", obs_f, obs_tag, it.f, it.tag);
                    end
                end
            end
        end
        in_valid = 1'b0;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain left=%0d want=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        item_t it;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; rand_ops(); d = 20'd5; mode = 2'd3; c = 20'd7; in_tag = 4'(i + 10);
            tick();
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1 || occupancy !== 3'd3) begin
            bad++; $display("FAIL arst_pre got=valid%0b occ%0d want=valid1 occ3", out_valid, occupancy);
        end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%0b want=0", out_valid); end
        total++; if (f !== '0) begin bad++; $display("FAIL arst_f got=%0h want=0", f); end
        total++; if (occupancy !== '0) begin bad++; $display("FAIL arst_occupancy got=%0d want=0", occupancy); end
        total++; if (in_ready !== 1'b1 || out_tag !== '0) begin
            bad++; $display("FAIL arst_ready_tag got=%0b/%0d want=1/0", in_ready, out_tag);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        mode = 2'd0; a = 20'd1; b = 20'd1; c = 20'd0; d = 20'd2; in_tag = 4'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (obs_xfer) break;
        end
        if (!obs_xfer || obs_qsize == 0) begin
            total++; bad++; $display("FAIL arst_timeout got=no_output want=output");
        end else begin
            it = exp_q.pop_front();
            total++; if (obs_f !== 40'd4 || obs_tag !== 4'd9) begin
                bad++; $display("FAIL arst_new_item got=%0h/%0d want=4/9", obs_f, obs_tag);
            end
            total++; if (obs_cyc - it.cyc != LAT) begin
                bad++; $display("FAIL arst_latency got=%0d want=%0d", obs_cyc - it.cyc, LAT);
            end
        end
        tick();
        total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL arst_stale got=%0b want=0", obs_valid); end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipel_stream.md
# pipel_stream

Parametrised, flow-controlled successor to the fixed three-input pipelined arithmetic block. It accepts operand sets on a valid/ready stream, computes one of four mode-selected arithmetic functions in a first register stage, and carries the result through DEPTH delay stages. A final registered multiply by `d` produces a full-width product. Each item carries a sideband tag, so downstream logic can match results to requests. The block sits between the operand source and the result consumer in the datapath.

## Interface
- `N`, 20, operand width
- `DEPTH`, 2, number of pure delay stages between op stage and multiply stage (≥0)
- `TAG_W`, 4, sideband tag width (≥1)

- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-high reset
- `in_valid` in 1: operand set offered
- `in_ready` out 1: block accepts this cycle
- `mode` in 2: function select, sampled with operands
- `a`, `b`, `c`, `d` in N each: unsigned operands
- `in_tag` in TAG_W: sideband tag, sampled with operands
- `out_valid` out 1: result available
- `out_ready` in 1: consumer accepts
- `f` out 2N: result
- `out_tag` out TAG_W: tag of result
- `occupancy` out $clog2(DEPTH+3): count of valid stages

## Operation
- Op stage function, modulo 2^N, unsigned:
  - `mode` 00: s = a+b
  - `mode` 01: s = a−b (wraps)
  - `mode` 10: s = (a+b)+(a−b)
  - `mode` 11: s = c
- The op stage registers s, d and the tag.
- Delay stages copy s, d and tag unchanged.
- Final stage registers f = s*d. The product is the full 2N-bit unsigned result; no truncation.
- Global stall: adv = !out_valid || out_ready. All stages shift only when adv=1. `in_ready` = adv, combinational.
- Accept = in_valid && in_ready. The op-stage valid loads Accept when adv=1.
- No bubble collapse: `in_ready` is low whenever the final stage holds data and out_ready=0, even if interior stages are empty.
- Transfer out = out_valid && out_ready.
- While stalled, all stage contents, f and out_tag hold stable.
- `occupancy` = number of stages (DEPTH+2 total) with valid set, updated each edge. Maximum is DEPTH+2.
- Results leave strictly in acceptance order. No item is lost or duplicated.
- Reset: all valid bits, data, tag and f registers go to 0 immediately.
  - Reset values: out_valid=0, f=0, out_tag=0, occupancy=0.
  - in_ready=1 during and after reset, because out_valid=0.
  - Items in flight when rst asserts are discarded.

## Timing
- Latency with no stall is DEPTH+2 cycles. An item accepted at edge k has out_valid=1 after edge k+DEPTH+1, and can be consumed at edge k+DEPTH+2.
- Throughput is one item per cycle while out_ready=1.
- A stall of m cycles delays every in-flight item by exactly m cycles.
- Simultaneous output transfer and input accept in the same cycle is legal and is the steady state.
- After out_ready rises from a stall, the next item appears on the following edge.
- DEPTH=0: latency 2, occupancy width 2.

## Structure
- `pipel_pkg`: `mode_t` enum (MODE_ADD, MODE_SUB, MODE_SUM2, MODE_PASSC) and the `OCC_W` width function.
- Sub-module `pipel_stage`: one enable-gated register stage carrying valid, data and tag, with async reset. It is instantiated DEPTH times via generate.
- The op stage and multiply stage are inline in `pipel_stream`.

## Test plan
Bench parameters: N=20, DEPTH=2.
- mode 00, a=3, b=5, d=7, tag=1, out_ready=1 -> f=56, out_tag=1, out_valid exactly 4 cycles after accept.
- mode 01, a=2, b=5, d=1 -> f=1048573 (wrapped difference). Mode 10, a=10, b=4, d=3 -> f=60.
- mode 11, c=0xFFFFF, d=0xFFFFF -> f=0xFFFFE00001 (full 40-bit product).
- Stream 6 back-to-back items with tags 0–5, out_ready low for 3 cycles mid-stream -> in_ready low exactly while out_valid && !out_ready. Outputs are in tag order 0–5 with f held stable during the stall. Occupancy peaks at 4.
- Accept 3 items, assert rst asynchronously mid-cycle -> out_valid, f and occupancy drop to 0 without waiting for a clock edge. After release, new item a=1, b=1, d=2 yields f=4 with 4-cycle latency and no stale output.
